// File: rtl/patbuf_arb.sv
// Arbiter for the pattern-buffer field RAM: the core, a host loader and an output streamer
// share a single RAM port. Grants have zero latency. Read data is returned with a one-cycle tag.
module patbuf_arb #(
  parameter int adr_width    = 8,
  parameter int d_width      = 8,
  parameter int starve_limit = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [adr_width-1:0] core_adr,
  input  logic [d_width-1:0]   core_wdata,
  output logic                 core_gnt,
  output logic                 core_rvalid,
  output logic [d_width-1:0]   core_rdata,
  input  logic                 host_valid,
  input  logic [adr_width-1:0] host_adr,
  input  logic [d_width-1:0]   host_wdata,
  output logic                 host_ready,
  input  logic                 str_req,
  input  logic [adr_width-1:0] str_adr,
  output logic                 str_gnt,
  output logic                 str_rvalid,
  output logic [d_width-1:0]   str_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [adr_width-1:0] ram_adr,
  output logic [d_width-1:0]   ram_wdata,
  input  logic [d_width-1:0]   ram_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CORE = 2'd1,
    TAG_STR  = 2'd2
  } tag_t;

  localparam logic [2:0] STARVE_LIM = 3'(starve_limit);

  tag_t       r_rd_tag;
  tag_t       w_rd_tag_nxt;
  logic [2:0] r_wait_cnt;
  logic [2:0] w_wait_nxt;
  logic       r_rr_last;
  logic       w_rr_nxt;
  logic       w_starve;
  logic       w_low_pend;
  logic       w_low_win;
  logic       w_pick_str;
  logic       w_core_gnt;
  logic       w_host_gnt;
  logic       w_str_gnt;

  assign w_starve = (r_wait_cnt >= STARVE_LIM);

  // Winner selection; rst forces every grant low so nothing reaches the RAM during reset
  always_comb begin
    w_low_pend = host_valid | str_req;
    w_low_win  = 1'b0;
    w_pick_str = 1'b0;
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    w_str_gnt  = 1'b0;
    if (host_valid && str_req) begin
      w_pick_str = ~r_rr_last;
    end else begin
      w_pick_str = str_req;
    end
    if (w_low_pend && (w_starve || !core_req)) begin
      w_low_win = 1'b1;
    end else begin
      w_low_win = 1'b0;
    end
    if (rst) begin
      w_core_gnt = 1'b0;
      w_host_gnt = 1'b0;
      w_str_gnt  = 1'b0;
    end else begin
      w_core_gnt = core_req & ~w_low_win;
      w_host_gnt = w_low_win & ~w_pick_str;
      w_str_gnt  = w_low_win & w_pick_str;
    end
  end

  // RAM bus mux: an idle bus is driven to all zeros
  always_comb begin
    ram_we    = 1'b0;
    ram_adr   = '0;
    ram_wdata = '0;
    if (w_core_gnt) begin
      ram_we    = core_we;
      ram_adr   = core_adr;
      ram_wdata = core_wdata;
    end else if (w_host_gnt) begin
      ram_we    = 1'b1;
      ram_adr   = host_adr;
      ram_wdata = host_wdata;
    end else if (w_str_gnt) begin
      ram_we    = 1'b0;
      ram_adr   = str_adr;
      ram_wdata = '0;
    end else begin
      ram_we    = 1'b0;
      ram_adr   = '0;
      ram_wdata = '0;
    end
  end

  // Next state for the starvation counter, round-robin pointer and read-return tag
  always_comb begin
    w_wait_nxt   = r_wait_cnt;
    w_rr_nxt     = r_rr_last;
    w_rd_tag_nxt = TAG_NONE;
    if (w_host_gnt || w_str_gnt) begin
      w_wait_nxt = 3'd0;
    end else if (w_low_pend) begin
      if (r_wait_cnt != 3'd7) begin
        w_wait_nxt = r_wait_cnt + 3'd1;
      end else begin
        w_wait_nxt = r_wait_cnt;
      end
    end else begin
      w_wait_nxt = 3'd0;
    end
    if (w_host_gnt) begin
      w_rr_nxt = 1'b0;
    end else if (w_str_gnt) begin
      w_rr_nxt = 1'b1;
    end else begin
      w_rr_nxt = r_rr_last;
    end
    if (w_core_gnt && !core_we) begin
      w_rd_tag_nxt = TAG_CORE;
    end else if (w_str_gnt) begin
      w_rd_tag_nxt = TAG_STR;
    end else begin
      w_rd_tag_nxt = TAG_NONE;
    end
  end

  // State registers; the tag clears on reset so that a read in flight returns no rvalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 3'd0;
      r_rr_last  <= 1'b1;
      r_rd_tag   <= TAG_NONE;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      r_rr_last  <= w_rr_nxt;
      r_rd_tag   <= w_rd_tag_nxt;
    end
  end

  assign core_gnt    = w_core_gnt;
  assign host_ready  = w_host_gnt;
  assign str_gnt     = w_str_gnt;
  assign ram_en      = w_core_gnt | w_host_gnt | w_str_gnt;
  assign core_rvalid = (r_rd_tag == TAG_CORE);
  assign str_rvalid  = (r_rd_tag == TAG_STR);
  assign core_rdata  = ram_rdata;
  assign str_rdata   = ram_rdata;

endmodule

// File: tb/tb_patbuf_arb.sv
// Directed bench for patbuf_arb: a table of per-cycle vectors with a small RAM model,
// plus hand-written reset and starvation-saturation sequences.
module tb_patbuf_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_req, core_we, host_valid, str_req;
  logic [7:0] core_adr, core_wdata, host_adr, host_wdata, str_adr;
  logic       core_gnt, core_rvalid, host_ready, str_gnt, str_rvalid;
  logic [7:0] core_rdata, str_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_adr, ram_wdata, ram_rdata;
  logic       d7_core_gnt, d7_core_rvalid, d7_host_ready, d7_str_gnt, d7_str_rvalid;
  logic [7:0] d7_core_rdata, d7_str_rdata, d7_ram_adr, d7_ram_wdata;
  logic       d7_ram_en, d7_ram_we;

  logic [7:0] mem [0:255];
  int         n_err = 0;
  int         n_chk = 0;

  localparam logic [2:0] G_C = 3'b100;
  localparam logic [2:0] G_H = 3'b010;
  localparam logic [2:0] G_S = 3'b001;
  localparam logic [2:0] G_0 = 3'b000;

  always #5 clk = ~clk;

  patbuf_arb #(.adr_width(8), .d_width(8), .starve_limit(4)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_valid(host_valid), .host_adr(host_adr), .host_wdata(host_wdata), .host_ready(host_ready),
    .str_req(str_req), .str_adr(str_adr), .str_gnt(str_gnt), .str_rvalid(str_rvalid), .str_rdata(str_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  patbuf_arb #(.adr_width(8), .d_width(8), .starve_limit(7)) u_dut7 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
    .core_gnt(d7_core_gnt), .core_rvalid(d7_core_rvalid), .core_rdata(d7_core_rdata),
    .host_valid(host_valid), .host_adr(host_adr), .host_wdata(host_wdata), .host_ready(d7_host_ready),
    .str_req(str_req), .str_adr(str_adr), .str_gnt(d7_str_gnt), .str_rvalid(d7_str_rvalid), .str_rdata(d7_str_rdata),
    .ram_en(d7_ram_en), .ram_we(d7_ram_we), .ram_adr(d7_ram_adr), .ram_wdata(d7_ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM model with registered read data, driven by the limit-4 instance
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_adr] <= ram_wdata;
      else        ram_rdata    <= mem[ram_adr];
    end
  end

  typedef struct {
    string      name;
    logic       rs;
    logic       cr, cwe;
    logic [7:0] cadr, cwd;
    logic       hv;
    logic [7:0] hadr, hwd;
    logic       sr;
    logic [7:0] sadr;
    logic [2:0] g;
    logic [1:0] rv;
    logic [7:0] rd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic rs, input logic cr, input logic cwe,
                              input logic [7:0] cadr, input logic [7:0] cwd, input logic hv,
                              input logic [7:0] hadr, input logic [7:0] hwd, input logic sr,
                              input logic [7:0] sadr, input logic [2:0] g, input logic [1:0] rv,
                              input logic [7:0] rd);
    vec_t v;
    v.name = nm; v.rs = rs; v.cr = cr; v.cwe = cwe; v.cadr = cadr; v.cwd = cwd;
    v.hv = hv; v.hadr = hadr; v.hwd = hwd; v.sr = sr; v.sadr = sadr;
    v.g = g; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  function automatic logic [1:0] rv_of(input logic [2:0] prev_g, input logic prev_we);
    if (prev_g == G_C && !prev_we) return 2'b10;
    else if (prev_g == G_S)        return 2'b01;
    else                           return 2'b00;
  endfunction

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_adr = 8'h00; core_wdata = 8'h00;
    host_valid = 1'b0; host_adr = 8'h00; host_wdata = 8'h00;
    str_req = 1'b0; str_adr = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    logic [17:0] exp_bus;
    if (v.rs) do_reset();
    @(negedge clk);
    core_req = v.cr; core_we = v.cwe; core_adr = v.cadr; core_wdata = v.cwd;
    host_valid = v.hv; host_adr = v.hadr; host_wdata = v.hwd;
    str_req = v.sr; str_adr = v.sadr;
    #1;
    chk({v.name, "_gnt"}, {29'd0, core_gnt, host_ready, str_gnt}, {29'd0, v.g});
    chk({v.name, "_rvalid"}, {30'd0, core_rvalid, str_rvalid}, {30'd0, v.rv});
    if (v.rv[1]) chk({v.name, "_core_rdata"}, {24'd0, core_rdata}, {24'd0, v.rd});
    if (v.rv[0]) chk({v.name, "_str_rdata"}, {24'd0, str_rdata}, {24'd0, v.rd});
    if (v.g == G_C)      exp_bus = {1'b1, v.cwe, v.cadr, v.cwd};
    else if (v.g == G_H) exp_bus = {1'b1, 1'b1, v.hadr, v.hwd};
    else if (v.g == G_S) exp_bus = {1'b1, 1'b0, v.sadr, 8'h00};
    else                 exp_bus = 18'd0;
    chk({v.name, "_ram_bus"}, {14'd0, ram_en, ram_we, ram_adr, ram_wdata}, {14'd0, exp_bus});
  endtask

  initial begin
    logic [2:0] pri [0:15];
    logic [2:0] prev;
    logic [2:0] sat_exp;
    for (int a = 0; a < 256; a++) mem[a] = ~8'(a);

    // Reset: grants held off while rst is high, even with every port requesting
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_adr = 8'h10; core_wdata = 8'h00;
    host_valid = 1'b1; host_adr = 8'h80; host_wdata = 8'h11;
    str_req = 1'b1; str_adr = 8'hE0;
    #2;
    chk("rst_hold_gnt", {28'd0, core_gnt, host_ready, str_gnt, ram_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    core_req = 1'b1; core_adr = 8'h10;
    #1;
    chk("pre_rst_core_gnt", {31'd0, core_gnt}, 32'd1);
    #2;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_drop_rvalid", {30'd0, core_rvalid, str_rvalid}, 32'd0);
    chk("rst_mid_gnt", {28'd0, core_gnt, host_ready, str_gnt, ram_en}, 32'd0);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    core_req = 1'b1; core_adr = 8'h25;
    #1;
    chk("post_rst_gnt", {31'd0, core_gnt}, 32'd1);
    chk("post_rst_adr", {24'd0, ram_adr}, 32'h25);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rst_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("post_rst_rdata", {24'd0, core_rdata}, 32'hDA);

    // Priority with starve_limit 4 and all three ports held
    pri = '{G_C, G_C, G_C, G_C, G_H, G_C, G_C, G_C, G_C, G_S, G_C, G_C, G_C, G_C, G_H, G_C};
    prev = G_0;
    for (int i = 0; i < 16; i++) begin
      vq.push_back(mk("pri", i == 0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h80, 8'h11, 1'b1, 8'hE0,
                      pri[i], rv_of(prev, 1'b0), (prev == G_C) ? 8'hEF : 8'h1F));
      prev = pri[i];
    end
    vq.push_back(mk("pri_idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                    G_0, 2'b10, 8'hEF));

    // Round-robin between host and streamer with the core idle
    prev = G_0;
    for (int i = 0; i < 8; i++) begin
      vq.push_back(mk("rr", i == 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h90, 8'h33, 1'b1, 8'hE0,
                      (i % 2 == 0) ? G_H : G_S, rv_of(prev, 1'b0), 8'h1F));
      prev = (i % 2 == 0) ? G_H : G_S;
    end

    // Host write then streamer read of the same address on the next cycle
    vq.push_back(mk("wr_host", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3F, 8'hA5, 1'b0, 8'h00,
                    G_H, 2'b00, 8'h00));
    vq.push_back(mk("wr_str", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3F,
                    G_S, 2'b00, 8'h00));
    vq.push_back(mk("wr_ret", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                    G_0, 2'b01, 8'hA5));

    // Core and streamer reads alternating every cycle
    prev = G_0;
    for (int i = 0; i < 16; i++) begin
      vq.push_back(mk("b2b", i == 0, i % 2 == 0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00,
                      i % 2 == 1, 8'hE0, (i % 2 == 0) ? G_C : G_S, rv_of(prev, 1'b0),
                      (prev == G_C) ? 8'hEF : 8'h1F));
      prev = (i % 2 == 0) ? G_C : G_S;
    end
    vq.push_back(mk("b2b_tail", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                    G_0, 2'b01, 8'h1F));

    foreach (vq[k]) apply(vq[k]);

    // Saturation on the starve_limit 7 instance: host wins on cycles 7 and 15
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_adr = 8'h10;
      host_valid = 1'b1; host_adr = 8'hA0; host_wdata = 8'h44;
      str_req = 1'b0;
      #1;
      sat_exp = (i == 7 || i == 15) ? G_H : G_C;
      chk($sformatf("sat7_c%0d", i), {29'd0, d7_core_gnt, d7_host_ready, d7_str_gnt}, {29'd0, sat_exp});
    end
    @(negedge clk);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
